seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scan controller that shares a single combinational hex-to-seven-segment decoder bank (segments A–G) among NUM_DIGITS display digits. It holds a tear-free double-buffered copy of the digit values and steps through them one at a time. For each digit it presents the 4-bit nibble to the shared decoder and drives a one-hot digit select, with a blanking interval at the start of every slot to suppress ghosting. It sits between the value-producing logic and the segment decoders/pad drivers.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits (>= 2).
- PRESCALE, 16: clock cycles per digit slot (> BLANK).
- BLANK, 2: cycles at slot start with segments disabled (0 = no blanking).

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- en  in  1  scan enable, level.
- load  in  1  one-cycle strobe; capture digits_in.
- digits_in  in  4*NUM_DIGITS  digit values; digit i = bits [4i+3:4i].
- nibble  out  4  value of the current digit, to the shared decoder inputs {in1,in2,in3,in4} (MSB = in1).
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable.
- seg_en  out  1  high when decoder outputs may drive the pads.
- frame_done  out  1  one-cycle pulse at end of each full frame.

## Operation
- Registers:
  - pend (4*NUM_DIGITS) plus pend_valid.
  - disp (4*NUM_DIGITS).
  - idx (clog2 NUM_DIGITS).
  - slot counter cnt (clog2 PRESCALE).
  - 2-bit state.
- All outputs are registered.
- load=1: pend <= digits_in, pend_valid <= 1. A later load overwrites an earlier one and only the latest is kept.
- Frame start is every edge that enters BLANK (or SHOW when BLANK=0) with idx=0. At frame start, if pend_valid: disp <= pend, pend_valid <= 0.
  - If load coincides with frame start, the transfer uses the old pend. The new value is captured into pend and shown from the next frame.
- FSM states:
  - IDLE: digit_sel=0, seg_en=0. If en=1, go to BLANK (or SHOW if BLANK=0) with idx=0, cnt=0 (frame start).
  - BLANK: digit_sel=onehot(idx), seg_en=0. When cnt==BLANK-1, go to SHOW.
  - SHOW: digit_sel=onehot(idx), seg_en=1. When cnt==PRESCALE-1, end the slot:
    - idx==NUM_DIGITS-1: frame_done=1 on that cycle; idx wraps to 0 (frame start).
    - otherwise idx++.
    - en=0 at slot end: go to IDLE.
    - en=1 at slot end: go to BLANK (or SHOW if BLANK=0).
- cnt increments every cycle in BLANK/SHOW and resets to 0 at each slot end.
- en deassertion mid-slot completes the current slot; the display is never truncated mid-digit. Re-enabling restarts at digit 0.
- nibble = disp[4*idx +: 4]. It is updated on the same edge that enters the slot and is stable for the whole slot. In IDLE nibble holds its last value.
- Reset (asynchronous, any state): state=IDLE; idx=0, cnt=0; pend=0, pend_valid=0, disp=0; nibble=0, digit_sel=0, seg_en=0, frame_done=0.

## Timing
- en rises at edge k: digit_sel=0001 and nibble=disp[3:0] from edge k+1. seg_en rises at edge k+1+BLANK.
- Slot length is exactly PRESCALE cycles. Frame length is NUM_DIGITS*PRESCALE cycles. No idle gap between slots while en=1.
- seg_en is low for exactly BLANK cycles per slot. digit_sel changes only on edges where seg_en is low (or BLANK=0).
- frame_done is high during the last SHOW cycle of digit NUM_DIGITS-1, one cycle only.
- Load-to-display latency: at most one frame plus one cycle.

## Test plan
1. NUM_DIGITS=4, PRESCALE=8, BLANK=2; load digits_in=16'hB4D1, en=1:
   - digit_sel walks 0001/0010/0100/1000 with nibbles 1, D, 4, B, each for 8 cycles.
   - seg_en pattern per slot: 00111111.
   - frame_done pulses every 32 cycles.
2. Load 16'h1234 mid-frame, then 16'h5678 two cycles later: the next frame shows only 8, 7, 6, 5. The current frame is unchanged.
3. Load coinciding with the frame-start edge: the old pend is displayed, and the new value appears one frame later.
4. en dropped in cycle 3 of a slot: the slot runs all 8 cycles, then the block is in IDLE with digit_sel=0 and seg_en=0. Re-enable restarts at digit 0.
5. rst_n asserted mid-SHOW (asynchronous, off-edge): all outputs go to 0 immediately. After release with en=1, scanning restarts at digit 0 showing nibble 0.
6. BLANK=0 build: seg_en stays high continuously while scanning; the slot, frame and frame_done periods are unchanged.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller: double-buffers digit values and walks a
// one-hot digit select across a shared hex decoder, blanking each slot start.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 16,
  parameter int BLANK      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              nibble,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    seg_en,
  output logic                    frame_done
);

  // state    | meaning
  // ST_IDLE  | scan stopped, digit select and segments off
  // ST_BLANK | digit selected, segments held off against ghosting
  // ST_SHOW  | digit selected, segments driven

  localparam int IDW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW  = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam state_t         ST_START   = (BLANK == 0) ? ST_SHOW : ST_BLANK;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]  BLANK_LAST = (BLANK > 0) ? CW'(BLANK - 1) : '0;
  localparam logic [IDW-1:0] IDX_LAST   = IDW'(NUM_DIGITS - 1);

  state_t            state, state_nxt;
  logic [IDW-1:0]    idx, idx_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [DW-1:0]     pend, pend_nxt;
  logic              pend_valid, pend_valid_nxt;
  logic [DW-1:0]     disp, disp_nxt;
  logic [3:0]        nibble_nxt;
  logic [NUM_DIGITS-1:0] digit_sel_nxt;
  logic              seg_en_nxt;
  logic              frame_done_nxt;
  logic              slot_start;
  logic              frame_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      cnt        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      disp       <= '0;
      nibble     <= '0;
      digit_sel  <= '0;
      seg_en     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      pend       <= pend_nxt;
      pend_valid <= pend_valid_nxt;
      disp       <= disp_nxt;
      nibble     <= nibble_nxt;
      digit_sel  <= digit_sel_nxt;
      seg_en     <= seg_en_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    slot_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_nxt  = ST_START;
          idx_nxt    = '0;
          cnt_nxt    = '0;
          slot_start = 1'b1;
        end
      end
      ST_BLANK: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == BLANK_LAST) state_nxt = ST_SHOW;
      end
      ST_SHOW: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDW'(1);
          // en is only honoured at slot boundaries so a digit is never cut short
          if (en) begin
            state_nxt  = ST_START;
            slot_start = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    frame_start = slot_start && (idx_nxt == '0);

    // transfer sees the old pend; a coincident load lands in pend for next frame
    disp_nxt       = (frame_start && pend_valid) ? pend : disp;
    pend_nxt       = pend;
    pend_valid_nxt = pend_valid && !frame_start;
    if (load) begin
      pend_nxt       = digits_in;
      pend_valid_nxt = 1'b1;
    end

    nibble_nxt     = slot_start ? disp_nxt[{idx_nxt, 2'b00} +: 4] : nibble;
    digit_sel_nxt  = (state_nxt == ST_IDLE) ? '0 : (NUM_DIGITS'(1) << idx_nxt);
    seg_en_nxt     = (state_nxt == ST_SHOW);
    frame_done_nxt = (state_nxt == ST_SHOW) && (cnt_nxt == CNT_LAST) &&
                     (idx_nxt == IDX_LAST);
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a blanking build and a no-blanking build share
// stimulus and are checked every cycle against a frame-position model.
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;

  logic [3:0]  nibble_a, nibble_b;
  logic [3:0]  digit_sel_a, digit_sel_b;
  logic        seg_en_a, seg_en_b;
  logic        frame_done_a, frame_done_b;

  int checks = 0;
  int errors = 0;

  // frame-position reference model
  bit          m_run;
  int          m_pos;
  logic [15:0] m_pend, m_disp;
  bit          m_pv;
  logic [3:0]  m_nib;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK(B)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
    .nibble(nibble_a), .digit_sel(digit_sel_a), .seg_en(seg_en_a),
    .frame_done(frame_done_a));

  seg_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
    .nibble(nibble_b), .digit_sel(digit_sel_b), .seg_en(seg_en_b),
    .frame_done(frame_done_b));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_pend = '0; m_disp = '0; m_pv = 0; m_nib = '0;
  endtask

  task automatic model_edge();
    bit fs;
    fs = 0;
    if (!m_run) begin
      if (en) begin m_run = 1; m_pos = 0; fs = 1; end
    end else if (m_pos % P == P - 1) begin
      if (!en) m_run = 0;
      else begin
        m_pos = (m_pos + 1) % (N * P);
        fs = (m_pos == 0);
      end
    end else begin
      m_pos++;
    end
    if (fs && m_pv) begin m_disp = m_pend; m_pv = 0; end
    if (load) begin m_pend = digits_in; m_pv = 1; end
    if (m_run) m_nib = 4'(m_disp >> (4 * (m_pos / P)));
  endtask

  task automatic check_all();
    logic [3:0] e_sel;
    e_sel = m_run ? 4'(1 << (m_pos / P)) : 4'b0;
    chk("nibble_a", 16'(nibble_a), 16'(m_nib));
    chk("nibble_b", 16'(nibble_b), 16'(m_nib));
    chk("digit_sel_a", 16'(digit_sel_a), 16'(e_sel));
    chk("digit_sel_b", 16'(digit_sel_b), 16'(e_sel));
    chk("seg_en_a", 16'(seg_en_a), 16'(m_run && (m_pos % P) >= B));
    chk("seg_en_b", 16'(seg_en_b), 16'(m_run));
    chk("frame_done_a", 16'(frame_done_a), 16'(m_run && m_pos == N * P - 1));
    chk("frame_done_b", 16'(frame_done_b), 16'(m_run && m_pos == N * P - 1));
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_nibble"}, 16'({nibble_a, nibble_b}), 16'h0);
    chk({tag, "_sel"}, 16'({digit_sel_a, digit_sel_b}), 16'h0);
    chk({tag, "_seg"}, 16'({seg_en_a, seg_en_b, frame_done_a, frame_done_b}), 16'h0);
  endtask

  // called at a falling edge; drives inputs for the next rising edge
  task automatic step(input logic e, input logic l, input logic [15:0] d);
    en = e; load = l; digits_in = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(en, 1'b0, digits_in);
  endtask

  task automatic wait_pos(input string tag, input int pos_mod, input int modulus);
    int k;
    k = 0;
    while (!(m_run && (m_pos % modulus) == pos_mod) && k < 200) begin
      step(1'b1, 1'b0, digits_in);
      k++;
    end
    chk({tag, "_timeout"}, 16'(k < 200), 16'h1);
  endtask

  initial begin
    logic [3:0] p1_nib [4];
    p1_nib = '{4'h1, 4'hD, 4'h4, 4'hB};
    model_reset();

    repeat (3) @(negedge clk);
    zero_outputs("reset");
    rst_n = 1'b1;

    // frame walk with 16'hB4D1 loaded before enabling
    step(1'b0, 1'b1, 16'hB4D1);
    step(1'b1, 1'b0, 16'h0000);
    for (int c = 0; c < N * P; c++) begin
      chk("p1_nibble", 16'(nibble_a), 16'(p1_nib[c / P]));
      chk("p1_sel", 16'(digit_sel_a), 16'(4'b0001 << (c / P)));
      chk("p1_seg", 16'(seg_en_a), 16'((c % P) >= 2));
      chk("p1_done", 16'(frame_done_a), 16'(c == N * P - 1));
      step(1'b1, 1'b0, 16'h0000);
    end
    run(40);

    // two loads in one frame: only the latest is shown
    wait_pos("p2", 13, N * P);
    step(1'b1, 1'b1, 16'h1234);
    step(1'b1, 1'b0, 16'h1234);
    step(1'b1, 1'b1, 16'h5678);
    run(70);

    // load coinciding with frame start
    wait_pos("p3a", N * P - 1, N * P);
    step(1'b1, 1'b1, 16'h9ACE);
    chk("p3_old_pend", 16'(nibble_a), 16'h8);
    run(70);

    // en dropped in cycle 3 of a slot
    wait_pos("p4", 2, P);
    step(1'b0, 1'b0, 16'h0);
    run(10);
    chk("p4_idle_sel", 16'(digit_sel_a), 16'h0);
    step(1'b1, 1'b0, 16'h0);
    chk("p4_restart", 16'(digit_sel_a), 16'h1);
    run(20);

    // asynchronous reset during SHOW
    wait_pos("p5", 5, P);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 zero_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 16'h0);
    chk("p5_restart_sel", 16'(digit_sel_a), 16'h1);
    chk("p5_restart_nib", 16'(nibble_a), 16'h0);
    run(40);

    // randomized traffic
    for (int i = 0; i < 900; i++)
      step(logic'($urandom_range(0, 24) != 0), logic'($urandom_range(0, 15) == 0),
           16'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
